// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch front end.
//   state_e    : fetch FSM states (BOOT, FETCH, HOLD)
//   redir_src_e: which source won the redirect priority select
//   RESET_VECTOR_DEF / EXC_VECTOR_DEF : default vector addresses
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    EXC    = 2'd3
  } redir_src_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational priority select of the redirect target.
// Priority: exception > jump > branch_taken. The target is word aligned
// (bits [1:0] forced to zero).
// Ports:
//   exception_i, jump_i, branch_taken_i : redirect requests
//   jump_target_i, branch_target_i      : candidate destinations
//   redirect_valid_o                    : any redirect requested
//   redirect_target_o                   : aligned winning target
//   redirect_src_o                      : winning source
module pc_redirect_mux
  import cpu_pkg::*;
#(
  parameter int unsigned     ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF[ADDR_W-1:0]
) (
  input  logic              exception_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_target_o,
  output redir_src_e        redirect_src_o
);

  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    raw_target     = '0;
    redirect_src_o = NONE;
    if (exception_i) begin
      raw_target     = EXC_VECTOR;
      redirect_src_o = EXC;
    end else if (jump_i) begin
      raw_target     = jump_target_i;
      redirect_src_o = JUMP;
    end else if (branch_taken_i) begin
      raw_target     = branch_target_i;
      redirect_src_o = BRANCH;
    end
  end

  assign redirect_valid_o  = (redirect_src_o != NONE);
  assign redirect_target_o = {raw_target[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction fetch sequencer.
// Owns the PC register, runs the level req/ack handshake with instruction
// memory and presents one fetched instruction at a time to decode.
// Ports:
//   clk, rst (sync, active high)
//   stall                       : decode backpressure
//   exception/jump/branch_taken : redirect requests (+ targets)
//   imem_req/imem_addr          : fetch request (imem_addr == pc)
//   imem_ack/imem_rdata         : fetch response for current imem_addr
//   pc                          : current fetch PC
//   instr_valid/instr/instr_pc  : fetched instruction to decode
//   flush                       : one-cycle pulse after a redirect
//   epc                         : exception return PC
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exception,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              flush,
  output logic [ADDR_W-1:0] epc
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] epc_q, epc_d;

  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  redir_src_e        redir_src;

  pc_redirect_mux #(
    .ADDR_W    (ADDR_W),
    .EXC_VECTOR(EXC_VECTOR)
  ) u_redirect_mux (
    .exception_i      (exception),
    .jump_i           (jump),
    .jump_target_i    (jump_target),
    .branch_taken_i   (branch_taken),
    .branch_target_i  (branch_target),
    .redirect_valid_o (redir_valid),
    .redirect_target_o(redir_target),
    .redirect_src_o   (redir_src)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    epc_d      = epc_q;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH, HOLD: begin
        if (redir_valid) begin
          // Redirect beats stall and discards any ack seen this cycle.
          state_d = FETCH;
          pc_d    = redir_target;
          valid_d = 1'b0;
          flush_d = 1'b1;
          if (redir_src == EXC) begin
            epc_d = valid_q ? instr_pc_q : pc_q;
          end
        end else if (state_q == FETCH) begin
          if (imem_ack) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(4);
            state_d    = stall ? HOLD : FETCH;
          end else begin
            valid_d = 1'b0;
          end
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      epc_q      <= epc_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign flush       = flush_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, exception, jump, branch_taken, imem_ack;
  logic [31:0] jump_target, branch_target, imem_rdata;
  logic        imem_req, instr_valid, flush;
  logic [31:0] imem_addr, pc, instr, instr_pc, epc;

  // Second instance with a reset vector near the top of the address space.
  logic        w_ack;
  logic        w_req, w_valid, w_flush;
  logic [31:0] w_addr, w_pc, w_instr, w_instr_pc, w_epc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .exception(exception),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .flush(flush), .epc(epc)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .exception(1'b0),
    .jump(1'b0), .jump_target(32'h0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(32'h1234_5678),
    .pc(w_pc), .instr_valid(w_valid), .instr(w_instr),
    .instr_pc(w_instr_pc), .flush(w_flush), .epc(w_epc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redir();
    exception = 0; jump = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; imem_ack = 0; imem_rdata = 0; w_ack = 0;
    jump_target = 0; branch_target = 0; clear_redir();
    step(); step();
    rst = 0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if ({instr_valid, flush} !== 2'b00) begin bad++; $display("FAIL reset_vf got=%b exp=00", {instr_valid, flush}); end
    total++; if ({instr, instr_pc, epc} !== 96'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {instr, instr_pc, epc}); end
  endtask

  task automatic test_sequential();
    step(); // BOOT -> FETCH
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL seq_first got=%b/%h exp=1/0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'hA0;
    step();
    total++; if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b1, 32'h0, 32'hA0, 32'h4}) begin bad++; $display("FAIL seq_ack0 got=%b/%h/%h/%h exp=1/0/a0/4", instr_valid, instr_pc, instr, imem_addr); end
    imem_rdata = 32'hA1;
    step();
    total++; if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b1, 32'h4, 32'hA1, 32'h8}) begin bad++; $display("FAIL seq_ack1 got=%b/%h/%h/%h exp=1/4/a1/8", instr_valid, instr_pc, instr, imem_addr); end
  endtask

  task automatic test_stall_hold();
    imem_rdata = 32'hA2; stall = 1;
    step();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({imem_req, instr_valid, instr_pc, instr, pc} !== {1'b0, 1'b1, 32'h8, 32'hA2, 32'hC}) begin bad++; $display("FAIL hold_%0d got=%b/%b/%h/%h/%h exp=0/1/8/a2/c", i, imem_req, instr_valid, instr_pc, instr, pc); end
      if (i < 2) step();
    end
    stall = 0;
    step();
    total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'hC, 1'b1}) begin bad++; $display("FAIL hold_release got=%b/%h/%b exp=1/c/1", imem_req, imem_addr, instr_valid); end
    step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL noack_drop got=%b exp=0", instr_valid); end
  endtask

  task automatic test_redirect();
    branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h200;
    imem_ack = 1; imem_rdata = 32'hDEAD;
    step();
    clear_redir(); imem_ack = 0;
    total++; if ({pc, flush, instr_valid} !== {32'h200, 1'b1, 1'b0}) begin bad++; $display("FAIL jmp_over_br got=%h/%b/%b exp=200/1/0", pc, flush, instr_valid); end
    total++; if ({instr, instr_pc} !== {32'hA2, 32'h8}) begin bad++; $display("FAIL ack_dropped got=%h/%h exp=a2/8", instr, instr_pc); end
    step();
    total++; if ({pc, flush} !== {32'h200, 1'b0}) begin bad++; $display("FAIL flush_pulse got=%h/%b exp=200/0", pc, flush); end
    branch_taken = 1; branch_target = 32'h103;
    step();
    clear_redir();
    total++; if ({pc, flush} !== {32'h100, 1'b1}) begin bad++; $display("FAIL br_align got=%h/%b exp=100/1", pc, flush); end
  endtask

  task automatic test_exception();
    jump = 1; jump_target = 32'h40;
    step();
    clear_redir();
    imem_ack = 1; imem_rdata = 32'hB0;
    step();
    total++; if ({instr_valid, instr_pc, pc} !== {1'b1, 32'h40, 32'h44}) begin bad++; $display("FAIL exc_setup got=%b/%h/%h exp=1/40/44", instr_valid, instr_pc, pc); end
    exception = 1;
    step();
    clear_redir(); imem_ack = 0;
    total++; if ({pc, epc, flush, instr_valid} !== {32'h80, 32'h40, 1'b1, 1'b0}) begin bad++; $display("FAIL exc_valid got=%h/%h/%b/%b exp=80/40/1/0", pc, epc, flush, instr_valid); end
    jump = 1; jump_target = 32'h44;
    step();
    clear_redir();
    total++; if ({pc, epc, instr_valid} !== {32'h44, 32'h40, 1'b0}) begin bad++; $display("FAIL jmp_keeps_epc got=%h/%h/%b exp=44/40/0", pc, epc, instr_valid); end
    exception = 1;
    step();
    clear_redir();
    total++; if ({pc, epc} !== {32'h80, 32'h44}) begin bad++; $display("FAIL exc_invalid got=%h/%h exp=80/44", pc, epc); end
    jump = 1; jump_target = 32'h300;
    step();
    exception = 1; branch_taken = 1; branch_target = 32'h100; jump_target = 32'h200;
    step();
    clear_redir();
    total++; if ({pc, epc, flush} !== {32'h80, 32'h300, 1'b1}) begin bad++; $display("FAIL exc_all got=%h/%h/%b exp=80/300/1", pc, epc, flush); end
  endtask

  task automatic test_wrap();
    rst = 1;
    step();
    rst = 0;
    total++; if ({w_req, w_addr} !== {1'b0, 32'hFFFF_FFF8}) begin bad++; $display("FAIL wrap_reset got=%b/%h exp=0/fffffff8", w_req, w_addr); end
    step();
    w_ack = 1;
    step();
    total++; if ({w_addr, w_instr_pc} !== {32'hFFFF_FFFC, 32'hFFFF_FFF8}) begin bad++; $display("FAIL wrap_1 got=%h/%h exp=fffffffc/fffffff8", w_addr, w_instr_pc); end
    step();
    w_ack = 0;
    total++; if ({w_addr, w_instr_pc, w_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin bad++; $display("FAIL wrap_2 got=%h/%h/%b exp=0/fffffffc/1", w_addr, w_instr_pc, w_valid); end
  endtask

  task automatic test_reset_in_hold();
    // dut sits in FETCH at pc=0 after the reset above
    imem_ack = 1; imem_rdata = 32'hC0; stall = 1;
    step();
    imem_ack = 0;
    total++; if ({imem_req, instr_valid, pc} !== {1'b0, 1'b1, 32'h4}) begin bad++; $display("FAIL rh_hold got=%b/%b/%h exp=0/1/4", imem_req, instr_valid, pc); end
    jump = 1; jump_target = 32'h500; rst = 1;
    step();
    rst = 0;
    total++; if ({imem_req, instr_valid, flush, pc} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL rh_reset got=%b/%b/%b/%h exp=0/0/0/0", imem_req, instr_valid, flush, pc); end
    total++; if ({instr, instr_pc, epc} !== 96'h0) begin bad++; $display("FAIL rh_regs got=%h exp=0", {instr, instr_pc, epc}); end
    step(); // jump still high but BOOT ignores it
    clear_redir(); stall = 0;
    total++; if ({imem_req, flush, pc} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL rh_boot got=%b/%b/%h exp=1/0/0", imem_req, flush, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect();
    test_exception();
    test_wrap();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the program counter register and instruction-memory fetch for the single-issue core.
- Chooses the next PC from these sources: reset vector, exception vector, jump, taken branch, or sequential PC+4.
- Runs the level-sensitive req/ack fetch handshake with instruction memory.
- Presents one fetched instruction at a time to decode, with stall backpressure and a one-cycle flush pulse on redirect.

Parameters:
- ADDR_W, 32, width of every address and data bus
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0080, target PC on exception

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept an instruction this cycle
- exception  in  1  redirect to EXC_VECTOR
- jump  in  1  redirect to jump_target
- jump_target  in  ADDR_W  jump destination
- branch_taken  in  1  redirect to branch_target
- branch_target  in  ADDR_W  branch destination
- imem_req  out  1  fetch request, level
- imem_addr  out  ADDR_W  fetch address; equals pc
- imem_ack  in  1  imem_rdata valid for imem_addr this cycle
- imem_rdata  in  ADDR_W  fetched word
- pc  out  ADDR_W  current fetch PC register
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  ADDR_W  fetched instruction
- instr_pc  out  ADDR_W  address of instr
- flush  out  1  one-cycle pulse on the cycle after a redirect
- epc  out  ADDR_W  exception return PC

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=BOOT, pc=RESET_VECTOR.
  - imem_req=0, instr_valid=0, flush=0.
  - instr=0, instr_pc=0, epc=0.
  - rst wins over every other input. Reset mid-fetch abandons the request and drops any held instruction.
- FSM states: BOOT, FETCH, HOLD.
  - BOOT: imem_req=0. Next cycle goes to FETCH unconditionally; redirects are ignored in BOOT.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: at the edge, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
    - If stall=1 in the ack cycle, go to HOLD; otherwise stay in FETCH.
    - No ack: hold pc and imem_req, wait indefinitely.
  - HOLD: imem_req=0. instr, instr_pc and instr_valid=1 are held. When stall=0, go to FETCH.
- Consumption:
  - Decode takes the instruction on any cycle with instr_valid=1 and stall=0.
  - In FETCH without an ack in that cycle, instr_valid<=0 at the next edge.
  - Back-to-back acks give one instruction per cycle, latency 1 from ack to instr_valid.
- Redirect priority: exception > jump > branch_taken.
  - Evaluated in FETCH and HOLD; redirect overrides stall.
  - At the edge: pc<=selected target with bits [1:0] forced to 0, instr_valid<=0, flush<=1 for exactly one cycle, state<=FETCH.
  - An imem_ack in the redirect cycle is discarded: pc does not become pc+4, and instr is not updated.
  - Exception: epc<=instr_pc if instr_valid=1, else pc. epc is unchanged on jump/branch.
  - Simultaneous exception+jump+branch: EXC_VECTOR only.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Outputs:
  - imem_req is decoded from state; it is registered-state-driven and has no combinational path from inputs.
  - imem_addr is wired to pc.
  - All other outputs are registers.
- Memory contract: the memory must tolerate imem_addr changing while imem_req stays high after a redirect. ack always refers to the current imem_addr.

Decomposition:
- Shared package cpu_pkg:
  - state enum {BOOT, FETCH, HOLD}
  - constants RESET_VECTOR_DEF, EXC_VECTOR_DEF
  - redirect-source enum {NONE, BRANCH, JUMP, EXC}
- One sub-module, pc_redirect_mux: combinational priority select producing redirect_valid, redirect_target and the source enum. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then ack every FETCH cycle:
  - imem_req=0 in cycle 1, then imem_addr sequence 0x0, 0x4, 0x8.
  - instr_pc follows one cycle later; instr_valid is continuous.
- stall=1 in an ack cycle at pc=0x8 for 3 cycles:
  - state HOLD, imem_req=0, instr_pc=0x8 held.
  - After stall falls, imem_addr=0xC.
- branch_taken with target 0x100 and jump with target 0x200 in the same cycle, ack also high:
  - next pc=0x200, flush=1 for one cycle, instr_valid=0.
  - The acked word is dropped.
- exception with instr_valid=1, instr_pc=0x40:
  - pc=0x80, epc=0x40.
  - Repeat with instr_valid=0 and pc=0x44: epc=0x44.
- RESET_VECTOR=32'hFFFF_FFF8, two acks:
  - imem_addr 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- rst asserted while in HOLD with a jump pending:
  - all outputs take reset values, pc=RESET_VECTOR, no flush pulse.
